// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DATA_W        = 16;
    localparam int DEPTH_W       = 11;
    localparam int FRAME_LEN_DEF = 1024;

    localparam logic [DATA_W-1:0] PATTERN_INIT = '1;

    function automatic logic [2:0] sat_inc3(input logic [2:0] value);
        return (value == 3'b111) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream; master is the read engine, slave is the FIFO/sink side.
interface fifo_rd_stream_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W,
    parameter int DEPTH_WIDTH = DEPTH_W
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic [DEPTH_WIDTH:0]  rd_water_level;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output rd_en,
        input  rd_data,
        input  rd_empty,
        input  rd_water_level,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output rd_empty,
        output rd_water_level,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Register-based circular buffer absorbing FIFO read latency; head is always visible.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int BUF_DEPTH  = 4,
    localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  not_empty,
    output logic [PTR_W:0]        occ
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   OCC_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage is cleared on reset so the stream data output reads zero out of reset.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign not_empty = (occ != '0);

endmodule

// File: rtl/fifo_rd_stream.sv
// Credit-controlled FIFO read engine presenting a framed valid/ready stream.
// Define FIFO_RD_CHECK_EN to build the decrementing-pattern checker (chk_err/err_cnt).
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W,
    parameter int DEPTH_WIDTH = DEPTH_W,
    parameter int RD_LATENCY  = 1,
    parameter int BUF_DEPTH   = 4,
    parameter int FRAME_LEN   = FRAME_LEN_DEF
) (
    input  logic                clk,
    input  logic                tb_rst,
    input  logic                en,
    fifo_rd_stream_if.master    bus,
    output logic                busy,
    output logic [31:0]         word_cnt,
    output logic                chk_err,
    output logic [2:0]          err_cnt
);

    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int INF_W = $clog2(RD_LATENCY + 1);
    localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_LEN - 1);

    state_t                state;
    logic [RD_LATENCY-1:0] lat_sr;
    logic [INF_W-1:0]      inflight;
    logic [OCC_W-1:0]      occ;
    logic                  credit_ok;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  beat;
    logic [FC_W-1:0]       frame_cnt;
    logic                  unused_level;

    assign unused_level = ^bus.rd_water_level;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(lat_sr[i]);
        end
    end

    // Outstanding reads already own a buffer slot, so the buffer can never overflow.
    assign credit_ok  = (int'(occ) + int'(inflight)) < BUF_DEPTH;
    assign bus.rd_en  = ~tb_rst & (state == RUN) & ~bus.rd_empty & credit_ok;

    assign beat        = buf_valid & bus.m_ready;
    assign bus.m_valid = buf_valid;
    assign bus.m_data  = head_data;
    assign bus.m_last  = (frame_cnt == FRAME_LAST) & buf_valid;

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk        (clk),
        .tb_rst     (tb_rst),
        .push       (lat_sr[RD_LATENCY-1]),
        .push_data  (bus.rd_data),
        .pop        (beat),
        .head_data  (head_data),
        .not_empty  (buf_valid),
        .occ        (occ)
    );

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            lat_sr <= '0;
        end else begin
            lat_sr <= RD_LATENCY'({lat_sr, bus.rd_en});
        end
    end

    // DRAIN waits for both outstanding reads and the downstream sink to empty the buffer.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if ((lat_sr == '0) && !buf_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            word_cnt  <= '0;
            frame_cnt <= '0;
        end else if (beat) begin
            word_cnt  <= word_cnt + 32'd1;
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FC_W'(1);
        end
    end

`ifdef FIFO_RD_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_word;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            exp_word <= DATA_WIDTH'(PATTERN_INIT);
            chk_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            chk_err <= beat && (head_data != exp_word);
            if (beat) begin
                exp_word <= exp_word - DATA_WIDTH'(1);
                if (head_data != exp_word) begin
                    err_cnt <= sat_inc3(err_cnt);
                end
            end
        end
    end
`else
    assign chk_err = 1'b0;
    assign err_cnt = 3'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: behavioural FIFO feeding the engine, scoreboard of words in load order.
module tb_fifo_rd_stream;
    import fifo_rd_pkg::*;

    localparam int FRAME = FRAME_LEN_DEF;
    localparam int BUFD  = 4;
`ifdef FIFO_RD_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk;
    logic        tb_rst;
    logic        en;
    logic        busy;
    logic [31:0] word_cnt;
    logic        chk_err;
    logic [2:0]  err_cnt;

    fifo_rd_stream_if #(.DATA_WIDTH(DATA_W), .DEPTH_WIDTH(DEPTH_W)) bus ();

    fifo_rd_stream #(
        .DATA_WIDTH  (DATA_W),
        .DEPTH_WIDTH (DEPTH_W),
        .RD_LATENCY  (1),
        .BUF_DEPTH   (BUFD),
        .FRAME_LEN   (FRAME)
    ) dut (
        .clk      (clk),
        .tb_rst   (tb_rst),
        .en       (en),
        .bus      (bus),
        .busy     (busy),
        .word_cnt (word_cnt),
        .chk_err  (chk_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, flushed by the shared reset.
    logic [15:0] fifo_mem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.rd_empty       = (wr_ptr == rd_ptr);
    assign bus.rd_water_level = 12'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (tb_rst) begin
            rd_ptr <= wr_ptr;
        end else if (bus.rd_en && (wr_ptr != rd_ptr)) begin
            bus.rd_data <= fifo_mem[rd_ptr % 4096];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    logic [15:0] exp_q [$];
    int unsigned beats;
    logic [15:0] exp_pat;
    logic [15:0] load_pat;
    bit          pend_chk;
    int          exp_err;
    int          checks = 0;
    int          errors = 0;
    bit          obs_valid;
    bit          obs_rd_en;
    int          last_seen;

    task automatic model_reset();
        exp_q.delete();
        beats     = 0;
        exp_pat   = 16'hFFFF;
        load_pat  = 16'hFFFF;
        pend_chk  = 1'b0;
        exp_err   = 0;
        last_seen = 0;
    endtask

    task automatic load_word(input bit corrupt, input logic [15:0] bad);
        logic [15:0] v;
        v = corrupt ? bad : load_pat;
        fifo_mem[wr_ptr % 4096] = v;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(v);
        load_pat = load_pat - 16'd1;
    endtask

    // One clock: drive m_ready, check protocol invariants and the head beat against the scoreboard.
    task automatic step(input bit rdy);
        int          inside_dut;
        bit          mism;
        logic [15:0] head;
        @(negedge clk);
        bus.m_ready = rdy;
        #1;
        obs_valid = bus.m_valid;
        obs_rd_en = bus.rd_en;
        checks++;
        if (bus.rd_en && bus.rd_empty) begin
            errors++;
            $display("[TB] FAIL rd_en_while_empty: rd_en=%0b rd_empty=%0b, required rd_en=0", bus.rd_en, bus.rd_empty);
        end
        inside_dut = exp_q.size() - (wr_ptr - rd_ptr);
        checks++;
        if (inside_dut > BUFD) begin
            errors++;
            $display("[TB] FAIL occupancy: words held=%0d, required <= %0d", inside_dut, BUFD);
        end
        checks++;
        if (word_cnt !== beats) begin
            errors++;
            $display("[TB] FAIL word_cnt: got %0d, required %0d", word_cnt, beats);
        end
        checks++;
        if (chk_err !== (CHK_ON & pend_chk)) begin
            errors++;
            $display("[TB] FAIL chk_err: got %0b, required %0b", chk_err, CHK_ON & pend_chk);
        end
        checks++;
        if (err_cnt !== (CHK_ON ? 3'(exp_err) : 3'd0)) begin
            errors++;
            $display("[TB] FAIL err_cnt: got %0d, required %0d", err_cnt, CHK_ON ? exp_err : 0);
        end
        pend_chk = 1'b0;
        checks++;
        if (bus.m_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL spurious_valid: m_valid=1 with m_data=%h, required no pending word", bus.m_data);
            end else begin
                if (bus.m_data !== exp_q[0]) begin
                    errors++;
                    $display("[TB] FAIL m_data: beat %0d got %h, required %h", beats, bus.m_data, exp_q[0]);
                end
                checks++;
                if (bus.m_last !== ((beats % FRAME) == FRAME - 1)) begin
                    errors++;
                    $display("[TB] FAIL m_last: beat %0d got %0b, required %0b", beats, bus.m_last, (beats % FRAME) == FRAME - 1);
                end
                if (rdy) begin
                    head = exp_q.pop_front();
                    mism = (head != exp_pat);
                    if (bus.m_last === 1'b1) last_seen++;
                    beats    = beats + 1;
                    exp_pat  = exp_pat - 16'd1;
                    pend_chk = mism;
                    if (mism && exp_err < 7) exp_err++;
                end
            end
        end else if (bus.m_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL m_last_idle: got %0b without m_valid, required 0", bus.m_last);
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        en = 1'b0;
        for (c = 0; c < 50 && busy !== 1'b0; c++) step(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, c);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({bus.rd_en, bus.m_valid, bus.m_data, bus.m_last, busy, word_cnt, chk_err, err_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL %s: rd_en=%0b m_valid=%0b m_data=%h m_last=%0b busy=%0b word_cnt=%0d chk_err=%0b err_cnt=%0d, required all 0",
                     name, bus.rd_en, bus.m_valid, bus.m_data, bus.m_last, busy, word_cnt, chk_err, err_cnt);
        end
    endtask

    task automatic test_reset();
        tb_rst      = 1'b1;
        en          = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        tb_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_stream();
        int first_rd = -1;
        int first_v  = -1;
        int end_c    = -1;
        for (int i = 0; i < 2048; i++) load_word(1'b0, 16'h0);
        en = 1'b1;
        for (int c = 0; c < 3000 && end_c < 0; c++) begin
            step(1'b1);
            if (obs_rd_en && first_rd < 0) first_rd = c;
            if (obs_valid && first_v < 0) first_v = c;
            if (exp_q.size() == 0) end_c = c;
        end
        checks++;
        if (end_c < 0) begin
            errors++;
            $display("[TB] FAIL full_timeout: %0d words left, required 0", exp_q.size());
        end
        checks++;
        if (first_v - first_rd != 2) begin
            errors++;
            $display("[TB] FAIL first_valid_latency: got %0d cycles, required 2", first_v - first_rd);
        end
        checks++;
        if (end_c - first_v + 1 != 2048) begin
            errors++;
            $display("[TB] FAIL no_bubbles: 2048 beats took %0d cycles, required 2048", end_c - first_v + 1);
        end
        checks++;
        if (last_seen != 2) begin
            errors++;
            $display("[TB] FAIL m_last_count: got %0d, required 2", last_seen);
        end
        step(1'b1);
        checks++;
        if (word_cnt !== 32'd2048 || err_cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL full_totals: word_cnt=%0d err_cnt=%0d, required 2048 and 0", word_cnt, err_cnt);
        end
        wait_idle("full");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 200; i++) load_word(1'b0, 16'h0);
        en = 1'b1;
        for (int c = 0; c < 1000 && exp_q.size() > 0; c++) step(c[0]);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL backpressure_timeout: %0d words left, required 0", exp_q.size());
        end
        wait_idle("backpressure");
    endtask

    task automatic test_short_burst();
        for (int i = 0; i < 3; i++) load_word(1'b0, 16'h0);
        en = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL short_timeout: %0d words left, required 0", exp_q.size());
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            checks++;
            if (obs_rd_en || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL short_hold: rd_en=%0b busy=%0b, required 0 and 1", obs_rd_en, busy);
            end
        end
        en = 1'b0;
        step(1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_drain_busy: got %0b, required 1", busy);
        end
        step(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_idle_busy: got %0b, required 0", busy);
        end
    endtask

    task automatic test_midop_reset();
        for (int i = 0; i < 8; i++) load_word(1'b0, 16'h0);
        en = 1'b1;
        for (int c = 0; c < 6; c++) step(1'b0);
        checks++;
        if (!obs_valid) begin
            errors++;
            $display("[TB] FAIL midop_valid: m_valid=0 before reset, required 1");
        end
        tb_rst = 1'b1;
        #1;
        check_reset_values("midop_reset_values");
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) load_word(1'b0, 16'h0);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) step(1'b1);
        step(1'b1);
        checks++;
        if (exp_q.size() != 0 || word_cnt !== 32'd5) begin
            errors++;
            $display("[TB] FAIL midop_restart: left=%0d word_cnt=%0d, required 0 and 5", exp_q.size(), word_cnt);
        end
        wait_idle("midop");
    endtask

    task automatic test_pattern_check();
        for (int i = 0; i < 20; i++) load_word(i == 10, 16'h1234);
        en = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) step(1'b1);
        step(1'b1);
        checks++;
        if (err_cnt !== (CHK_ON ? 3'd1 : 3'd0)) begin
            errors++;
            $display("[TB] FAIL single_error: err_cnt=%0d, required %0d", err_cnt, CHK_ON ? 1 : 0);
        end
        for (int i = 0; i < 16; i++) load_word(i % 2 == 0, 16'h1234);
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) step(1'b1);
        step(1'b1);
        checks++;
        if (err_cnt !== (CHK_ON ? 3'd7 : 3'd0) || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL saturation: err_cnt=%0d left=%0d, required %0d and 0", err_cnt, exp_q.size(), CHK_ON ? 7 : 0);
        end
        wait_idle("pattern");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) load_word($urandom_range(15) == 0, 16'($urandom));
        for (int c = 0; c < 6000 && exp_q.size() > 0; c++) begin
            en = (c > 3000) ? 1'b1 : ($urandom_range(3) != 0);
            step(1'($urandom_range(1)));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_timeout: %0d words left, required 0", exp_q.size());
        end
        wait_idle("random");
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_backpressure();
        test_short_burst();
        test_midop_reset();
        test_pattern_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
